// File: rtl/iluminacao_pkg.sv
// Shared types and constants for the lighting controller.
package iluminacao_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        DESLIGADA     = 3'd0,
        LIGADA_AUTO   = 3'd1,
        LIGADA_MANUAL = 3'd2,
        INIBIDA       = 3'd3
    } estado_t;

    // Moore output pair {lamp, timer enable} for a given state.
    function automatic logic [1:0] moore_out(input estado_t s);
        logic [1:0] o;
        o = 2'b00;
        case (s)
            LIGADA_AUTO:   o = 2'b11;
            LIGADA_MANUAL: o = 2'b10;
            default:       o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/controle_iluminacao_debouncer.sv
// Push-button debouncer: accepts a level change after DEBOUNCE_T consecutive
// differing samples and emits a one-cycle press pulse on each accepted 0->1 flip.
module debouncer
    import iluminacao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_T = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic press
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_T - 1);

    logic             stable;
    logic [CNT_W-1:0] count;

    // The pulse is registered on the same edge that flips the stable level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (din == stable) begin
                count <= '0;
            end else if (count == DEB_LAST) begin
                stable <= din;
                count  <= '0;
                press  <= din;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/controle_iluminacao.sv
// Lighting controller FSM: manual/automatic lamp control with post-switch-off
// infrared inhibit. Optional manual-mode timeout enabled by MANUAL_TIMEOUT_EN.
module controle_iluminacao
    import iluminacao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_T   = 50,
    parameter int unsigned INHIBIT_T    = 1000,
    parameter int unsigned MANUAL_MAX_T = 60000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_button,
    input  logic infravermelho,
    input  logic C,
    output logic L,
    output logic enable_timer
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_T - 1);

    if (DEBOUNCE_T < 1 || DEBOUNCE_T > 65535) begin : g_bad_debounce
        $fatal(1, "DEBOUNCE_T out of range");
    end
    if (INHIBIT_T < 1 || INHIBIT_T > 65535) begin : g_bad_inhibit
        $fatal(1, "INHIBIT_T out of range");
    end
    if (MANUAL_MAX_T < 1 || MANUAL_MAX_T > 65535) begin : g_bad_manual
        $fatal(1, "MANUAL_MAX_T out of range");
    end

    estado_t          state;
    logic [CNT_W-1:0] count;
    logic             press;

    debouncer #(
        .DEBOUNCE_T(DEBOUNCE_T)
    ) u_debouncer (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (push_button),
        .press(press)
    );

`ifdef MANUAL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] MAN_LAST = CNT_W'(MANUAL_MAX_T - 1);
`endif

    // Outputs are registered from the state being entered, so they stay Moore.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= DESLIGADA;
            count        <= '0;
            L            <= 1'b0;
            enable_timer <= 1'b0;
        end else begin
            case (state)
                DESLIGADA: begin
                    if (press) begin
                        state <= LIGADA_MANUAL;
                        count <= '0;
                        {L, enable_timer} <= moore_out(LIGADA_MANUAL);
                    end else if (infravermelho) begin
                        state <= LIGADA_AUTO;
                        count <= '0;
                        {L, enable_timer} <= moore_out(LIGADA_AUTO);
                    end else begin
                        {L, enable_timer} <= moore_out(DESLIGADA);
                    end
                end
                LIGADA_AUTO: begin
                    if (press) begin
                        state <= INIBIDA;
                        count <= '0;
                        {L, enable_timer} <= moore_out(INIBIDA);
                    end else if (C) begin
                        state <= DESLIGADA;
                        count <= '0;
                        {L, enable_timer} <= moore_out(DESLIGADA);
                    end else begin
                        {L, enable_timer} <= moore_out(LIGADA_AUTO);
                    end
                end
                LIGADA_MANUAL: begin
                    if (press) begin
                        state <= INIBIDA;
                        count <= '0;
                        {L, enable_timer} <= moore_out(INIBIDA);
`ifdef MANUAL_TIMEOUT_EN
                    end else if (count == MAN_LAST) begin
                        state <= DESLIGADA;
                        count <= '0;
                        {L, enable_timer} <= moore_out(DESLIGADA);
                    end else begin
                        if (count != '1) begin
                            count <= count + 1'b1;
                        end
                        {L, enable_timer} <= moore_out(LIGADA_MANUAL);
                    end
`else
                    end else begin
                        {L, enable_timer} <= moore_out(LIGADA_MANUAL);
                    end
`endif
                end
                INIBIDA: begin
                    if (press) begin
                        state <= LIGADA_MANUAL;
                        count <= '0;
                        {L, enable_timer} <= moore_out(LIGADA_MANUAL);
                    end else if (count == INH_LAST) begin
                        state <= DESLIGADA;
                        count <= '0;
                        {L, enable_timer} <= moore_out(DESLIGADA);
                    end else begin
                        if (count != '1) begin
                            count <= count + 1'b1;
                        end
                        {L, enable_timer} <= moore_out(INIBIDA);
                    end
                end
                default: begin
                    state <= DESLIGADA;
                    count <= '0;
                    {L, enable_timer} <= moore_out(DESLIGADA);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_iluminacao.sv
// Directed scoreboard bench for controle_iluminacao with short timing parameters.
// Builds with or without MANUAL_TIMEOUT_EN.
module tb_controle_iluminacao;
    import iluminacao_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned INH = 10;
    localparam int unsigned MAN = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic push_button = 1'b0;
    logic infravermelho = 1'b0;
    logic C = 1'b0;
    logic L;
    logic enable_timer;

    typedef struct {
        string   tag;
        logic    l;
        logic    en;
        estado_t st;
    } expect_t;

    expect_t sb[$];
    int errors = 0;
    int checks = 0;

    controle_iluminacao #(
        .DEBOUNCE_T  (DEB),
        .INHIBIT_T   (INH),
        .MANUAL_MAX_T(MAN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_button  (push_button),
        .infravermelho(infravermelho),
        .C            (C),
        .L            (L),
        .enable_timer (enable_timer)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        expect_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            check_val({e.tag, ".L"}, 16'(L), 16'(e.l));
            check_val({e.tag, ".enable_timer"}, 16'(enable_timer), 16'(e.en));
            check_val({e.tag, ".state"}, 16'(dut.state), 16'(e.st));
        end
    endtask

    task automatic apply_stimulus(input logic pb, input logic ir, input logic c,
                                  input logic l, input logic en, input estado_t st,
                                  input string tag);
        expect_t e;
        push_button   = pb;
        infravermelho = ir;
        C             = c;
        e.tag = tag;
        e.l   = l;
        e.en  = en;
        e.st  = st;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic hold(input int n, input logic pb, input logic ir, input logic c,
                        input logic l, input logic en, input estado_t st, input string tag);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(pb, ir, c, l, en, st, tag);
        end
    endtask

    initial begin
        $display("[TB] start");

        rst_n = 1'b0;
        hold(2, 0, 0, 0, 0, 0, DESLIGADA, "reset");
        check_val("reset_count", dut.count, 16'd0);
        rst_n = 1'b1;

        hold(3, 1, 0, 0, 0, 0, DESLIGADA, "short_press");
        hold(2, 0, 0, 0, 0, 0, DESLIGADA, "short_release");
        check_val("short_no_pulse", 16'(dut.press), 16'd0);

        hold(3, 1, 0, 0, 0, 0, DESLIGADA, "press_debounce");
        apply_stimulus(1, 0, 0, 0, 0, DESLIGADA, "press_accept");
        check_val("press_pulse", 16'(dut.press), 16'd1);
        apply_stimulus(1, 0, 0, 1, 0, LIGADA_MANUAL, "enter_manual");
        check_val("press_single", 16'(dut.press), 16'd0);
        hold(4, 1, 0, 0, 1, 0, LIGADA_MANUAL, "manual_held");
        hold(4, 0, 0, 0, 1, 0, LIGADA_MANUAL, "manual_release");
        check_val("release_no_pulse", 16'(dut.press), 16'd0);
        apply_stimulus(0, 0, 1, 1, 0, LIGADA_MANUAL, "manual_ignores_c");
        apply_stimulus(0, 0, 0, 1, 0, LIGADA_MANUAL, "manual_idle");

        hold(4, 1, 0, 0, 1, 0, LIGADA_MANUAL, "manual_off_debounce");
        apply_stimulus(1, 0, 0, 0, 0, INIBIDA, "manual_to_inhibit");
        hold(9, 0, 1, 0, 0, 0, INIBIDA, "inhibit_ignores_ir");
        apply_stimulus(0, 1, 0, 0, 0, DESLIGADA, "inhibit_expire");
        apply_stimulus(0, 1, 0, 1, 1, LIGADA_AUTO, "auto_after_inhibit");

        apply_stimulus(0, 0, 1, 0, 0, DESLIGADA, "auto_c_off");
        apply_stimulus(0, 1, 0, 1, 1, LIGADA_AUTO, "ir_on");
        apply_stimulus(0, 0, 1, 0, 0, DESLIGADA, "c_off");
        apply_stimulus(0, 1, 0, 1, 1, LIGADA_AUTO, "ir_on_again");
        hold(2, 0, 0, 0, 1, 1, LIGADA_AUTO, "auto_hold");

        hold(4, 1, 0, 0, 1, 1, LIGADA_AUTO, "auto_press_debounce");
        apply_stimulus(1, 0, 1, 0, 0, INIBIDA, "press_beats_c");
        hold(9, 0, 1, 0, 0, 0, INIBIDA, "inhibit_from_auto");
        apply_stimulus(0, 1, 0, 0, 0, DESLIGADA, "inhibit_from_auto_expire");
        apply_stimulus(0, 1, 0, 1, 1, LIGADA_AUTO, "auto_again");

        hold(4, 1, 1, 0, 1, 1, LIGADA_AUTO, "auto_press2");
        apply_stimulus(1, 1, 0, 0, 0, INIBIDA, "inhibit2");
        hold(4, 0, 1, 0, 0, 0, INIBIDA, "inhibit2_release");
        hold(4, 1, 1, 0, 0, 0, INIBIDA, "inhibit2_press");
        apply_stimulus(1, 1, 0, 1, 0, LIGADA_MANUAL, "inhibit_to_manual");

        hold(4, 0, 0, 0, 1, 0, LIGADA_MANUAL, "manual2_release");
`ifdef MANUAL_TIMEOUT_EN
        hold(15, 0, 0, 0, 1, 0, LIGADA_MANUAL, "manual_before_timeout");
        apply_stimulus(0, 0, 0, 0, 0, DESLIGADA, "manual_timeout");
        hold(4, 1, 0, 0, 0, 0, DESLIGADA, "reenter_debounce");
        apply_stimulus(1, 0, 0, 1, 0, LIGADA_MANUAL, "reenter_manual");
`else
        hold(100, 0, 0, 0, 1, 0, LIGADA_MANUAL, "manual_no_timeout");
`endif

        hold(2, 1, 0, 0, 1, 0, LIGADA_MANUAL, "held_before_reset");
        rst_n = 1'b0;
        apply_stimulus(1, 0, 0, 0, 0, DESLIGADA, "mid_reset");
        check_val("mid_reset_count", dut.count, 16'd0);
        check_val("mid_reset_deb_count", dut.u_debouncer.count, 16'd0);
        check_val("mid_reset_stable", 16'(dut.u_debouncer.stable), 16'd0);
        check_val("mid_reset_press", 16'(dut.press), 16'd0);
        rst_n = 1'b1;
        hold(3, 1, 0, 0, 0, 0, DESLIGADA, "post_reset_debounce");
        check_val("post_reset_no_early_pulse", 16'(dut.press), 16'd0);
        apply_stimulus(1, 0, 0, 0, 0, DESLIGADA, "post_reset_accept");
        check_val("post_reset_pulse", 16'(dut.press), 16'd1);
        apply_stimulus(1, 0, 0, 1, 0, LIGADA_MANUAL, "post_reset_manual");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
